// File: rtl/cp0_pkg.sv
// cp0_pkg: shared CP0 register indices, field layout and EPC source encodings.
package cp0_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam int ST_IE   = 0;
    localparam int ST_EXL  = 1;
    localparam int IM_LSB  = 8;
    localparam int IP_LSB  = 8;
    typedef enum logic [1:0] {
        EPC_IF  = 2'b00,
        EPC_ID  = 2'b01,
        EPC_EXE = 2'b10,
        EPC_MEM = 2'b11
    } epc_sel_e;
    function automatic logic [31:0] status_word(input logic ie, input logic exl, input logic [7:0] im);
        return {16'b0, im, 6'b0, exl, ie};
    endfunction
    function automatic logic [31:0] cause_word(input logic bd, input logic [7:0] ip, input logic [4:0] exc);
        return {bd, 15'b0, ip, 1'b0, exc, 2'b0};
    endfunction
endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare pair with prescaler and sticky timer-pending bit.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_irq
);
    logic [3:0]  div_q, div_d;
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        pend_q, pend_d, tick;
    always_comb begin
        tick      = div_q == 4'(COUNT_DIV - 1);
        div_d     = (count_we || tick) ? 4'd0 : div_q + 4'd1;
        count_d   = count_we ? wdata : tick ? count_q + 32'd1 : count_q;
        compare_d = compare_we ? wdata : compare_q;
        // A Compare write clears pending even if a match is seen that same cycle
        pend_d    = compare_we ? 1'b0 : (count_q == compare_q) ? 1'b1 : pend_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            pend_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end
    assign count     = count_q;
    assign compare   = compare_q;
    assign timer_irq = pend_q;
endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: MIPS CP0 Status/Cause/EPC/Count/Compare with exception updates and
// interrupt summary outputs for the control stage.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter int          COUNT_DIV  = 1,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        writestatus,
    input  logic        writecause,
    input  logic        writeepc,
    input  logic        exl,
    input  logic        ie,
    input  logic        db,
    input  logic [4:0]  exccode,
    input  logic [1:0]  selepc,
    input  logic [31:0] pc_if,
    input  logic [31:0] pc_id,
    input  logic [31:0] pc_exe,
    input  logic [31:0] pc_mem,
    input  logic        mtc0,
    input  logic        mfc0,
    input  logic [4:0]  cp0_idx,
    input  logic [31:0] wdata,
    input  logic [4:0]  ext_int,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        intr,
    output logic [7:0]  imip,
    output logic        timer_irq
);
    logic        ie_q, ie_d, exl_q, exl_d, bd_q, bd_d;
    logic [7:0]  im_q, im_d, ip;
    logic [4:0]  exc_q, exc_d, ext_q;
    logic [1:0]  swip_q, swip_d;
    logic [31:0] epc_q, epc_d, epc_src, count, compare;
    logic        wr_status, wr_cause, wr_epc;
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_we   (mtc0 && cp0_idx == CP0_COUNT),
        .compare_we (mtc0 && cp0_idx == CP0_COMPARE),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .timer_irq  (timer_irq)
    );
    always_comb begin
        wr_status = mtc0 && cp0_idx == CP0_STATUS;
        wr_cause  = mtc0 && cp0_idx == CP0_CAUSE;
        wr_epc    = mtc0 && cp0_idx == CP0_EPC;
        epc_src   = selepc == EPC_MEM ? pc_mem : selepc == EPC_EXE ? pc_exe :
                    selepc == EPC_ID  ? pc_id  : pc_if;
        // Exception strobes take precedence over mtc0 on the fields they own
        ie_d      = writestatus ? ie  : wr_status ? wdata[ST_IE]  : ie_q;
        exl_d     = writestatus ? exl : wr_status ? wdata[ST_EXL] : exl_q;
        im_d      = wr_status ? wdata[IM_LSB +: 8] : im_q;
        bd_d      = writecause ? db : bd_q;
        exc_d     = writecause ? exccode : exc_q;
        swip_d    = wr_cause ? wdata[IP_LSB +: 2] : swip_q;
        epc_d     = writeepc ? epc_src : wr_epc ? wdata : epc_q;
        ip        = {timer_irq, ext_q, swip_q};
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q   <= STATUS_RST[ST_IE];
            exl_q  <= STATUS_RST[ST_EXL];
            im_q   <= STATUS_RST[IM_LSB +: 8];
            bd_q   <= 1'b0;
            exc_q  <= '0;
            swip_q <= '0;
            ext_q  <= '0;
            epc_q  <= '0;
        end else begin
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            im_q   <= im_d;
            bd_q   <= bd_d;
            exc_q  <= exc_d;
            swip_q <= swip_d;
            ext_q  <= ext_int;
            epc_q  <= epc_d;
        end
    end
    assign rdata = !mfc0                   ? 32'd0 :
                   cp0_idx == CP0_COUNT    ? count :
                   cp0_idx == CP0_COMPARE  ? compare :
                   cp0_idx == CP0_STATUS   ? status_word(ie_q, exl_q, im_q) :
                   cp0_idx == CP0_CAUSE    ? cause_word(bd_q, ip, exc_q) :
                   cp0_idx == CP0_EPC      ? epc_q : 32'd0;
    assign epc  = epc_q;
    assign intr = ie_q & ~exl_q;
    assign imip = im_q & ip;
endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed checks of CP0 register file; a second instance covers COUNT_DIV=4.
module tb_cp0_regs;
    logic        clk = 0, rst_n = 0;
    logic        writestatus = 0, writecause = 0, writeepc = 0, exl = 0, ie = 0, db = 0;
    logic [4:0]  exccode = 0, cp0_idx = 0, ext_int = 0;
    logic [1:0]  selepc = 0;
    logic [31:0] pc_if = 0, pc_id = 0, pc_exe = 0, pc_mem = 0, wdata = 0;
    logic        mtc0 = 0, mfc0 = 0;
    logic [31:0] rdata1, epc1, rdata4, epc4, v;
    logic        intr1, tirq1, intr4, tirq4;
    logic [7:0]  imip1, imip4;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    cp0_regs #(.COUNT_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .writestatus(writestatus), .writecause(writecause),
        .writeepc(writeepc), .exl(exl), .ie(ie), .db(db), .exccode(exccode), .selepc(selepc),
        .pc_if(pc_if), .pc_id(pc_id), .pc_exe(pc_exe), .pc_mem(pc_mem), .mtc0(mtc0), .mfc0(mfc0),
        .cp0_idx(cp0_idx), .wdata(wdata), .ext_int(ext_int), .rdata(rdata1), .epc(epc1),
        .intr(intr1), .imip(imip1), .timer_irq(tirq1));

    cp0_regs #(.COUNT_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .writestatus(writestatus), .writecause(writecause),
        .writeepc(writeepc), .exl(exl), .ie(ie), .db(db), .exccode(exccode), .selepc(selepc),
        .pc_if(pc_if), .pc_id(pc_id), .pc_exe(pc_exe), .pc_mem(pc_mem), .mtc0(mtc0), .mfc0(mfc0),
        .cp0_idx(cp0_idx), .wdata(wdata), .ext_int(ext_int), .rdata(rdata4), .epc(epc4),
        .intr(intr4), .imip(imip4), .timer_irq(tirq4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] d);
        mtc0 = 1; cp0_idx = idx; wdata = d;
        step();
        mtc0 = 0;
    endtask

    task automatic rd1(input logic [4:0] idx, output logic [31:0] r);
        mfc0 = 1; cp0_idx = idx; #1; r = rdata1; mfc0 = 0;
    endtask

    task automatic rd4(input logic [4:0] idx, output logic [31:0] r);
        mfc0 = 1; cp0_idx = idx; #1; r = rdata4; mfc0 = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; step(); step(); rst_n = 1;
        n_cmp++; if ({intr1, imip1, tirq1, epc1} !== 41'd0) begin n_bad++; $display("FAIL reset_outs got %h want 0", {intr1, imip1, tirq1, epc1}); end
        mfc0 = 0; cp0_idx = 12; #1;
        n_cmp++; if (rdata1 !== 0) begin n_bad++; $display("FAIL rdata_nomfc0 got %h want 0", rdata1); end
        rd1(12, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_status got %h want 0", v); end
        rd1(13, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_cause got %h want 0", v); end
        rd1(14, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL reset_epc got %h want 0", v); end
        rd1(11, v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_compare got %h want ffffffff", v); end
    endtask

    task automatic test_timer();
        wr(12, 32'h0000_8001);
        wr(9, 32'd0);
        wr(11, 32'd5);
        wr(9, 32'd0);
        rd1(9, v); n_cmp++; if (v !== 32'd0) begin n_bad++; $display("FAIL count_start got %h want 0", v); end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++; if (tirq1 !== 1'b0) begin n_bad++; $display("FAIL timer_early count=%0d got %b want 0", i, tirq1); end
        end
        rd1(9, v); n_cmp++; if (v !== 32'd5) begin n_bad++; $display("FAIL count_at5 got %h want 5", v); end
        step();
        n_cmp++; if ({tirq1, intr1, imip1} !== {1'b1, 1'b1, 8'h80}) begin n_bad++; $display("FAIL timer_rise got irq=%b intr=%b imip=%h want 1 1 80", tirq1, intr1, imip1); end
        rd1(13, v); n_cmp++; if (v !== 32'h0000_8000) begin n_bad++; $display("FAIL cause_ip7 got %h want 00008000", v); end
        step(); step();
        n_cmp++; if (tirq1 !== 1'b1) begin n_bad++; $display("FAIL timer_sticky got %b want 1", tirq1); end
        wr(11, 32'd100);
        n_cmp++; if ({tirq1, imip1} !== 9'h0) begin n_bad++; $display("FAIL timer_clear got irq=%b imip=%h want 0 00", tirq1, imip1); end
        rd1(11, v); n_cmp++; if (v !== 32'd100) begin n_bad++; $display("FAIL compare_rd got %h want 64", v); end
    endtask

    task automatic test_exception();
        writestatus = 1; writecause = 1; writeepc = 1; exl = 1; ie = 0; db = 1;
        exccode = 5'd12; selepc = 2'b11; pc_mem = 32'h40; pc_id = 32'h1234;
        step();
        writestatus = 0; writecause = 0; writeepc = 0;
        rd1(12, v); n_cmp++; if (v !== 32'h0000_8002) begin n_bad++; $display("FAIL exc_status got %h want 00008002", v); end
        rd1(13, v); n_cmp++; if (v !== 32'h8000_0030) begin n_bad++; $display("FAIL exc_cause got %h want 80000030", v); end
        n_cmp++; if ({epc1, intr1} !== {32'h40, 1'b0}) begin n_bad++; $display("FAIL exc_epc got epc=%h intr=%b want 00000040 0", epc1, intr1); end
        writeepc = 1; selepc = 2'b01; step(); writeepc = 0;
        n_cmp++; if (epc1 !== 32'h1234) begin n_bad++; $display("FAIL epc_sel_id got %h want 00001234", epc1); end
    endtask

    task automatic test_priority();
        writestatus = 1; ie = 1; exl = 0;
        wr(12, 32'h0);
        writestatus = 0;
        rd1(12, v); n_cmp++; if (v !== 32'h0000_0001) begin n_bad++; $display("FAIL prio_status got %h want 00000001", v); end
        n_cmp++; if (intr1 !== 1'b1) begin n_bad++; $display("FAIL prio_intr got %b want 1", intr1); end
        writeepc = 1; selepc = 2'b10; pc_exe = 32'h88;
        wr(14, 32'h99);
        writeepc = 0;
        n_cmp++; if (epc1 !== 32'h88) begin n_bad++; $display("FAIL prio_epc got %h want 00000088", epc1); end
        wr(14, 32'h99);
        n_cmp++; if (epc1 !== 32'h99) begin n_bad++; $display("FAIL mtc0_epc got %h want 00000099", epc1); end
    endtask

    task automatic test_count_div();
        wr(9, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            rd4(9, v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hold%0d got %h want ffffffff", i, v); end
            step();
        end
        rd4(9, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL div_wrap got %h want 0", v); end
        step(); step();
        wr(9, 32'd10);
        rd4(9, v); n_cmp++; if (v !== 32'd10) begin n_bad++; $display("FAIL div_load got %h want a", v); end
        step(); step(); step();
        rd4(9, v); n_cmp++; if (v !== 32'd10) begin n_bad++; $display("FAIL div_load_hold got %h want a", v); end
        step();
        rd4(9, v); n_cmp++; if (v !== 32'd11) begin n_bad++; $display("FAIL div_load_inc got %h want b", v); end
    endtask

    task automatic test_ext_int();
        wr(12, 32'h0000_0400);
        ext_int = 5'b00001; #1;
        n_cmp++; if (imip1 !== 8'h00) begin n_bad++; $display("FAIL ext_latency got %h want 00", imip1); end
        step();
        n_cmp++; if (imip1 !== 8'h04) begin n_bad++; $display("FAIL ext_imip got %h want 04", imip1); end
        wr(13, 32'hFFFF_FFFF);
        rd1(13, v); n_cmp++; if (v !== 32'h8000_0730) begin n_bad++; $display("FAIL cause_swip got %h want 80000730", v); end
        wr(5, 32'hDEAD_BEEF);
        rd1(5, v); n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped got %h want 0", v); end
    endtask

    task automatic test_reset_mid();
        wr(12, 32'h0000_FF01);
        n_cmp++; if ({intr1, imip1} !== {1'b1, 8'h07}) begin n_bad++; $display("FAIL pre_reset got intr=%b imip=%h want 1 07", intr1, imip1); end
        rst_n = 0; step(); rst_n = 1;
        n_cmp++; if ({intr1, imip1, tirq1, epc1} !== 41'd0) begin n_bad++; $display("FAIL mid_reset got %h want 0", {intr1, imip1, tirq1, epc1}); end
        rd1(11, v); n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mid_reset_compare got %h want ffffffff", v); end
    endtask

    initial begin
        test_reset();
        test_timer();
        test_exception();
        test_priority();
        test_count_div();
        test_ext_int();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
